// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target model: FSM states, bus condition codes,
// bus level constants and field widths.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  // Open-drain line level a receiver drives/reads for an acknowledge.
  localparam logic ACK_LVL  = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [1:0] {
    COND_NONE,
    COND_START,
    COND_STOP
  } i2c_cond_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_MACK
  } i2c_state_e;

endpackage

// File: rtl/i2c_target_model_if.sv
// Bus pins and local register-file port of the I2C target, grouped for
// connection between the target (slave) and its driver (master).
interface i2c_target_model_if
  import i2c_pkg::*;
#(
  parameter int REG_COUNT = 16
);
  localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  logic                  scl_i;
  logic                  sda_i;
  logic                  sda_oe;
  logic                  host_we;
  logic [IDX_W-1:0]      host_addr;
  logic [I2C_BYTE_W-1:0] host_wdata;
  logic [I2C_BYTE_W-1:0] host_rdata;
  logic                  busy;
  logic                  wr_pulse;
  logic [IDX_W-1:0]      wr_index;
  logic                  collision;

  modport slave (
    input  scl_i, sda_i, host_we, host_addr, host_wdata,
    output sda_oe, host_rdata, busy, wr_pulse, wr_index, collision
  );

  modport master (
    output scl_i, sda_i, host_we, host_addr, host_wdata,
    input  sda_oe, host_rdata, busy, wr_pulse, wr_index, collision
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes the SCL/SDA pair and derives SCL edges and START/STOP
// conditions from the synchronized levels only.
module i2c_line_sync
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      scl_i,
  input  logic      sda_i,
  output logic      sda,
  output logic      scl_rise,
  output logic      scl_fall,
  output i2c_cond_e cond
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda      = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;

  always_comb begin
    cond = COND_NONE;
    if (scl_s && scl_d && sda_d && !sda) begin
      cond = COND_START;
    end else if (scl_s && scl_d && !sda_d && sda) begin
      cond = COND_STOP;
    end
  end

endmodule

// File: rtl/i2c_target_model.sv
// I2C target with a 7-bit address, byte register file with auto-incrementing
// pointer, ACK generation and read-back; local host port shares the file.
module i2c_target_model
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] ADDR        = 7'h3C,
  parameter int                    REG_COUNT   = 16,
  parameter int                    SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  i2c_target_model_if.slave bus
);

  localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic idx_t idx_of(input logic [I2C_BYTE_W-1:0] b);
    logic [31:0] m;
    m = {24'd0, b} % REG_COUNT;
    return m[IDX_W-1:0];
  endfunction

  function automatic idx_t idx_next(input idx_t i);
    return (32'(i) == REG_COUNT - 1) ? '0 : i + 1'b1;
  endfunction

  i2c_state_e            state;
  logic [2:0]            bit_cnt;
  logic [I2C_BYTE_W-1:0] shreg;
  logic                  ack_phase;
  logic                  rw;
  idx_t                  ptr;
  logic [I2C_BYTE_W-1:0] regs [REG_COUNT];

  logic                  sda_s;
  logic                  scl_rise;
  logic                  scl_fall;
  i2c_cond_e             cond;

  logic [I2C_BYTE_W-1:0] rx_byte;
  logic [I2C_BYTE_W-1:0] rd_byte;
  logic                  i2c_we;
  logic                  host_hit;
  logic                  host_drop;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (bus.scl_i),
    .sda_i    (bus.sda_i),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .cond     (cond)
  );

  assign rx_byte   = {shreg[I2C_BYTE_W-2:0], sda_s};
  assign rd_byte   = regs[ptr];
  assign i2c_we    = (cond == COND_NONE) && scl_rise && (bit_cnt == 3'd7) && (state == ST_WDATA);
  assign host_hit  = bus.host_we && (32'(bus.host_addr) < REG_COUNT);
  assign host_drop = host_hit && i2c_we && (bus.host_addr == ptr);

  assign bus.host_rdata = (32'(bus.host_addr) < REG_COUNT) ? regs[bus.host_addr] : '0;

  // START/STOP outrank bit-level activity; bits are taken on SCL rise and the
  // line is only changed on SCL fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      ack_phase     <= 1'b0;
      rw            <= 1'b0;
      ptr           <= '0;
      bus.sda_oe    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.wr_pulse  <= 1'b0;
      bus.wr_index  <= '0;
      bus.collision <= 1'b0;
    end else begin
      bus.wr_pulse  <= i2c_we;
      bus.collision <= host_drop;
      if (i2c_we) begin
        bus.wr_index <= ptr;
      end

      if (cond == COND_START) begin
        state      <= ST_ADDR;
        bit_cnt    <= '0;
        ack_phase  <= 1'b0;
        bus.sda_oe <= 1'b0;
      end else if (cond == COND_STOP) begin
        state      <= ST_IDLE;
        ack_phase  <= 1'b0;
        bus.sda_oe <= 1'b0;
        bus.busy   <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ack_phase <= 1'b0;
              if (state == ST_ADDR) begin
                if (rx_byte[I2C_BYTE_W-1:1] == ADDR) begin
                  state    <= ST_ADDR_ACK;
                  rw       <= rx_byte[0];
                  bus.busy <= 1'b1;
                end else begin
                  state    <= ST_IDLE;
                  bus.busy <= 1'b0;
                end
              end else if (state == ST_PTR) begin
                ptr   <= idx_of(rx_byte);
                state <= ST_PTR_ACK;
              end else begin
                ptr   <= idx_next(ptr);
                state <= ST_WDATA_ACK;
              end
            end
          end
          ST_RDATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state     <= ST_MACK;
              ack_phase <= 1'b0;
            end
          end
          ST_MACK: begin
            // Master NACK ends the read; the bus is left for STOP/START.
            if (ack_phase && sda_s != ACK_LVL) begin
              state     <= ST_IDLE;
              ack_phase <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (!ack_phase) begin
              bus.sda_oe <= 1'b1;
              ack_phase  <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              if (state == ST_ADDR_ACK && rw == RW_READ) begin
                shreg      <= {rd_byte[I2C_BYTE_W-2:0], 1'b0};
                bus.sda_oe <= ~rd_byte[I2C_BYTE_W-1];
                ptr        <= idx_next(ptr);
                state      <= ST_RDATA;
              end else begin
                bus.sda_oe <= 1'b0;
                state      <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
              end
            end
          end
          ST_RDATA: begin
            bus.sda_oe <= ~shreg[I2C_BYTE_W-1];
            shreg      <= {shreg[I2C_BYTE_W-2:0], 1'b0};
          end
          ST_MACK: begin
            if (!ack_phase) begin
              bus.sda_oe <= 1'b0;
              ack_phase  <= 1'b1;
            end else begin
              ack_phase  <= 1'b0;
              bit_cnt    <= '0;
              shreg      <= {rd_byte[I2C_BYTE_W-2:0], 1'b0};
              bus.sda_oe <= ~rd_byte[I2C_BYTE_W-1];
              ptr        <= idx_next(ptr);
              state      <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // I2C write has priority; a host write to the same index that cycle is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (i2c_we) begin
        regs[ptr] <= rx_byte;
      end
      if (host_hit && !host_drop) begin
        regs[bus.host_addr] <= bus.host_wdata;
      end
    end
  end

endmodule
